fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port jump  in  1  redirect from decode; 0 = taken, 1 = not taken.
REQ-004 SHALL have port new_pc  in  16  redirect target from decode; bit 0 forced to 0 internally.
REQ-005 SHALL have port stall  in  1  hazard hold; 1 = freeze PC and IF/ID.
REQ-006 SHALL have port imem_addr  out  16  fetch address; held constant while a request is outstanding.
REQ-007 SHALL have port imem_req  out  1  fetch request; held until imem_ready.
REQ-008 SHALL have port imem_ready  in  1  response strobe; imem_rdata valid when 1.
REQ-009 SHALL have port imem_rdata  in  16  instruction word.
REQ-010 SHALL have port pc_out  out  16  IF/ID PC; drives decode pc_in.
REQ-011 SHALL have port ir_out  out  16  IF/ID instruction; drives decode ir_in.
REQ-012 SHALL have port OPCP2  out  16  IF/ID PC+2; drives decode IPCP2.
REQ-013 SHALL have port valid_out  out  1  IF/ID holds a real instruction.

Function
REQ-014 SHALL implement states REQ (request outstanding), HOLD (response parked in skid buffer during stall), and DISCARD (squashed request awaiting its response).
REQ-015 In REQ, SHALL drive imem_req=1 and imem_addr=PC; in HOLD, imem_req=0.
REQ-016 In REQ with imem_ready=1, stall=0, jump=1, SHALL load IF/ID on that edge: ir_out=imem_rdata, pc_out=PC, OPCP2=PC+2, valid_out=1, then PC<=PC+2 and the next request is issued the following cycle (1-cycle latency from ready to ir_out).
REQ-017 In REQ with imem_ready=1, stall=1, jump=1, SHALL park rdata and PC in the skid buffer, hold IF/ID and PC, and go to HOLD.
REQ-018 In HOLD, on the first edge with stall=0, SHALL move the skid contents into IF/ID, set PC<=skid PC+2, and return to REQ.
REQ-019 On any edge with jump=0, SHALL set PC<=new_pc, set ir_out=0x0000 (NOP), set valid_out=0, and clear the skid buffer; jump overrides stall.
REQ-020 On jump=0 in REQ with imem_ready=0, SHALL go to DISCARD, keeping imem_req=1 and the old imem_addr; on the response, it SHALL drop the data and go to REQ at new_pc.
REQ-021 On jump=0 with imem_ready=1, or in HOLD, SHALL drop any response and enter REQ at new_pc next cycle.
REQ-022 With stall=1 and no response, SHALL keep IF/ID, PC and the request unchanged.
REQ-023 SHALL compute PC+2 modulo 2^16 (0xFFFE+2=0x0000), with OPCP2 wrapping identically.
REQ-024 SHALL allow at most one outstanding imem request.

Reset
REQ-025 While reset=1, outputs SHALL be: PC=0x0000, pc_out=0, ir_out=0, OPCP2=0, valid_out=0, skid empty, state=REQ; imem_req SHALL be 0 during reset.
REQ-026 Reset mid-request SHALL abandon the outstanding request; the first request after release SHALL be at 0x0000.

Structure
REQ-027 A shared package SHALL hold RESET_PC=0x0000, NOP=0x0000, INSTR_W=16, and the state encoding.
REQ-028 The IF/ID register (load/hold/flush) SHALL be the sub-module if_id_reg; the PC and FSM SHALL stay in fetch_stage.

Verification
REQ-029 Reset release, memory always ready, rdata=addr^0xA5A5, one instruction per cycle -> pc_out = 0, 2, 4, ... with OPCP2 = pc_out+2 and valid_out=1 from cycle 2.
REQ-030 Stall asserted 3 cycles while a response for PC=0x0006 arrives -> ir_out unchanged during the stall; 1 cycle after release, pc_out=0x0006; no fetch is lost or duplicated.
REQ-031 jump=0, new_pc=0x0041 with a request pending (ready 2 cycles later) -> DISCARD, stale data never reaches ir_out, next fetch address 0x0040, valid_out=0 for the bubble.
REQ-032 jump=0 and stall=1 on the same edge, new_pc=0x0100 -> redirect wins, ir_out=0x0000, next imem_addr=0x0100.
REQ-033 Redirect to new_pc=0xFFFE, then two fetches -> pc_out=0xFFFE then 0x0000, with OPCP2=0x0000 then 0x0002.
REQ-034 reset pulsed while a request is outstanding with ready withheld -> all outputs 0 immediately, and the first post-reset imem_addr=0x0000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
//
// Shared definitions for the instruction fetch stage: datapath widths, reset
// and bubble constants, the fetch FSM state encoding, the IF/ID register
// command encoding and the packet type that travels from fetch into IF/ID.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [ADDR_W-1:0]  RESET_PC = 16'h0000;
  localparam logic [INSTR_W-1:0] NOP      = 16'h0000;

  // Fetch FSM states.
  //   S_REQ     : a request to imem is outstanding at the current PC
  //   S_HOLD    : a response arrived during a stall and is parked in the skid
  //   S_DISCARD : the outstanding request was squashed by a redirect; its
  //               response must be swallowed before fetching the new target
  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  // IF/ID register commands.
  typedef enum logic [1:0] {
    IFID_HOLD  = 2'd0,
    IFID_LOAD  = 2'd1,
    IFID_FLUSH = 2'd2
  } ifid_op_e;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ir;
  } fetch_pkt_t;

  // Sequential successor of a PC; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(2);
  endfunction

  // Instructions are halfword aligned, so bit 0 of any target is dropped.
  function automatic logic [ADDR_W-1:0] pc_align(input logic [ADDR_W-1:0] pc);
    return pc & ~ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
//
// IF/ID pipeline register between fetch and decode. It holds one instruction,
// its address, its sequential successor address and a valid flag.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high; clears every field
//   op         : IFID_LOAD loads load_pkt, IFID_FLUSH turns the entry into a
//                NOP bubble, IFID_HOLD keeps the current contents
//   load_pkt   : instruction and PC to capture on IFID_LOAD
//   pc_out     : PC of the held instruction
//   ir_out     : held instruction word (NOP when flushed)
//   pcp2_out   : pc_out + 2, wrapping at 2^16
//   valid_out  : entry holds a real instruction
// -----------------------------------------------------------------------------
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  ifid_op_e           op,
  input  fetch_pkt_t         load_pkt,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INSTR_W-1:0] ir_out,
  output logic [ADDR_W-1:0]  pcp2_out,
  output logic               valid_out
);

  // NOTE: state is updated only with non-blocking assignments inside a
  // clocked block; the reset branch sits in the same block and its edge is in
  // the sensitivity list so clearing happens without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_out    <= '0;
      ir_out    <= NOP;
      pcp2_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      case (op)
        IFID_LOAD: begin
          pc_out    <= load_pkt.pc;
          ir_out    <= load_pkt.ir;
          pcp2_out  <= pc_inc(load_pkt.pc);
          valid_out <= 1'b1;
        end
        IFID_FLUSH: begin
          // The PC fields are left alone; decode ignores them when invalid.
          ir_out    <= NOP;
          valid_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage. Owns the PC and a three-state fetch FSM that keeps
// at most one imem request outstanding, parks a response that arrives during a
// decode stall in a one-entry skid buffer, and swallows the response of a
// request squashed by a redirect. Fetched instructions are handed to decode
// through the if_id_reg sub-module.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high
//   jump       : redirect from decode, active low (0 = taken)
//   new_pc     : redirect target; bit 0 is ignored
//   stall      : 1 freezes PC and IF/ID (a redirect still wins)
//   imem_addr  : fetch address, stable while a request is outstanding
//   imem_req   : fetch request, held until imem_ready; 0 during reset
//   imem_ready : response strobe, imem_rdata valid when 1
//   imem_rdata : instruction word returned by imem
//   pc_out     : IF/ID PC
//   ir_out     : IF/ID instruction
//   OPCP2      : IF/ID PC + 2
//   valid_out  : IF/ID holds a real instruction
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic               stall,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_req,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INSTR_W-1:0] ir_out,
  output logic [ADDR_W-1:0]  OPCP2,
  output logic               valid_out
);

  fetch_state_e      state_q,   state_d;
  logic [ADDR_W-1:0] pc_q,      pc_d;
  // Address of a squashed request; imem still expects it on imem_addr until
  // the response comes back, while pc_q already points at the new target.
  logic [ADDR_W-1:0] stale_q,   stale_d;
  fetch_pkt_t        skid_q,    skid_d;

  ifid_op_e          ifid_op;
  fetch_pkt_t        ifid_pkt;

  logic              taken;
  assign taken = ~jump;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      stale_q <= RESET_PC;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
      skid_q  <= skid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state, PC, skid and IF/ID control
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a
    // latch.
    state_d   = state_q;
    pc_d      = pc_q;
    stale_d   = stale_q;
    skid_d    = skid_q;
    ifid_op   = IFID_HOLD;
    ifid_pkt  = '{pc: pc_q, ir: imem_rdata};
    imem_req  = 1'b0;
    imem_addr = pc_q;

    case (state_q)
      S_REQ: begin
        imem_req = 1'b1;
        if (taken) begin
          // Redirect beats stall. A response arriving on this edge belongs
          // to the wrong path and is dropped; without one, the request is
          // still in flight and must be drained in S_DISCARD.
          pc_d    = pc_align(new_pc);
          ifid_op = IFID_FLUSH;
          skid_d  = '0;
          if (!imem_ready) begin
            stale_d = pc_q;
            state_d = S_DISCARD;
          end
        end else if (imem_ready) begin
          if (stall) begin
            // Decode cannot accept it yet; park it and keep the PC.
            skid_d  = '{pc: pc_q, ir: imem_rdata};
            state_d = S_HOLD;
          end else begin
            ifid_op = IFID_LOAD;
            pc_d    = pc_inc(pc_q);
          end
        end else if (!stall) begin
          // Decode consumed the held instruction and nothing new arrived:
          // present a bubble rather than repeat it.
          ifid_op = IFID_FLUSH;
        end
      end

      S_HOLD: begin
        if (taken) begin
          pc_d    = pc_align(new_pc);
          ifid_op = IFID_FLUSH;
          skid_d  = '0;
          state_d = S_REQ;
        end else if (!stall) begin
          ifid_op  = IFID_LOAD;
          ifid_pkt = skid_q;
          pc_d     = pc_inc(skid_q.pc);
          skid_d   = '0;
          state_d  = S_REQ;
        end
      end

      S_DISCARD: begin
        // Keep presenting the squashed request so the single outstanding
        // transaction completes cleanly; its data is never used.
        imem_req  = 1'b1;
        imem_addr = stale_q;
        if (taken) begin
          pc_d    = pc_align(new_pc);
          ifid_op = IFID_FLUSH;
        end
        if (imem_ready) begin
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase

    // The request is combinational from state, so it is masked explicitly
    // while reset is held.
    if (reset) begin
      imem_req = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID pipeline register
  // ---------------------------------------------------------------------------
  if_id_reg u_if_id_reg (
    .clk       (clk),
    .reset     (reset),
    .op        (ifid_op),
    .load_pkt  (ifid_pkt),
    .pc_out    (pc_out),
    .ir_out    (ir_out),
    .pcp2_out  (OPCP2),
    .valid_out (valid_out)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed scenarios followed by a randomized run. The reference model is an
// in-order stream scoreboard: every instruction decode consumes (valid_out=1
// on an edge with stall=0 and no redirect) must be the next address of the
// program-order stream, carry imem word addr^KEY and report addr+2. A taken
// redirect restarts the stream at the aligned target. A bus monitor checks
// that an unanswered request keeps its address until it is answered.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [15:0] KEY = 16'hA5A5;

  logic        clk = 1'b0;
  logic        reset;
  logic        jump;
  logic [15:0] new_pc;
  logic        stall;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [15:0] pc_out;
  logic [15:0] ir_out;
  logic [15:0] OPCP2;
  logic        valid_out;

  int          n_checks = 0;
  int          n_errors = 0;

  // Scoreboard / monitor state
  logic [15:0] exp_pc;
  logic        prev_wait;
  logic [15:0] prev_addr;
  int          consumed;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .jump       (jump),
    .new_pc     (new_pc),
    .stall      (stall),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .pc_out     (pc_out),
    .ir_out     (ir_out),
    .OPCP2      (OPCP2),
    .valid_out  (valid_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, expv, $time);
    end
  endtask

  // One clock cycle, called at (or just after) a falling edge. Runs the
  // monitor and scoreboard against the outputs now visible, applies the
  // inputs for the coming rising edge and waits for the next falling edge.
  task automatic cycle(input logic s, input logic j, input logic [15:0] np,
                       input logic rdy);
    if (prev_wait) begin
      check("req_held", 16'(imem_req), 16'd1);
      check("addr_held", imem_addr, prev_addr);
    end
    stall      = s;
    jump       = j;
    new_pc     = np;
    imem_ready = rdy & imem_req;
    imem_rdata = imem_req ? (imem_addr ^ KEY) : 16'h0000;
    if (!j) begin
      exp_pc = np & 16'hFFFE;
    end else if (!s && valid_out) begin
      check("sb_pc", pc_out, exp_pc);
      check("sb_ir", ir_out, exp_pc ^ KEY);
      check("sb_opcp2", OPCP2, exp_pc + 16'd2);
      exp_pc = exp_pc + 16'd2;
      consumed++;
    end
    prev_wait = imem_req & ~imem_ready;
    prev_addr = imem_addr;
    @(negedge clk);
  endtask

  task automatic model_reset();
    exp_pc    = 16'h0000;
    prev_wait = 1'b0;
    prev_addr = 16'h0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        rs, rj, rr;
    logic [15:0] rnp;
    int          consumed_before;

    reset      = 1'b1;
    jump       = 1'b1;
    stall      = 1'b0;
    new_pc     = 16'h0000;
    imem_ready = 1'b0;
    imem_rdata = 16'h0000;
    consumed   = 0;
    model_reset();

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_pc_out", pc_out, 16'h0000);
    check("rst_ir_out", ir_out, 16'h0000);
    check("rst_opcp2", OPCP2, 16'h0000);
    check("rst_valid", 16'(valid_out), 16'd0);
    check("rst_req", 16'(imem_req), 16'd0);
    check("rst_addr", imem_addr, 16'h0000);

    // ---------------- streaming, memory always ready ----------------
    reset = 1'b0;
    #1;
    check("first_addr", imem_addr, 16'h0000);
    check("first_req", 16'(imem_req), 16'd1);
    check("first_valid", 16'(valid_out), 16'd0);
    cycle(1'b0, 1'b1, 16'h0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      check("strm_pc", pc_out, 16'(2 * (k - 1)));
      check("strm_ir", ir_out, 16'(2 * (k - 1)) ^ KEY);
      check("strm_opcp2", OPCP2, 16'(2 * k));
      check("strm_valid", 16'(valid_out), 16'd1);
      check("strm_addr", imem_addr, 16'(2 * k));
      // The response for 0x0006 arrives on the first stalled edge.
      cycle(k == 3, 1'b1, 16'h0, 1'b1);
    end

    // ---------------- stall while response for 0x0006 arrives ----------------
    for (int k = 0; k < 2; k++) begin
      check("stall_ir", ir_out, 16'h0004 ^ KEY);
      check("stall_pc", pc_out, 16'h0004);
      check("stall_req", 16'(imem_req), 16'd0);
      cycle(1'b1, 1'b1, 16'h0, 1'b1);
    end
    check("stall_ir_last", ir_out, 16'h0004 ^ KEY);
    cycle(1'b0, 1'b1, 16'h0, 1'b1);
    check("unstall_pc", pc_out, 16'h0006);
    check("unstall_ir", ir_out, 16'h0006 ^ KEY);
    check("unstall_opcp2", OPCP2, 16'h0008);
    check("unstall_addr", imem_addr, 16'h0008);
    cycle(1'b0, 1'b1, 16'h0, 1'b1);
    check("after_stall_pc", pc_out, 16'h0008);
    check("after_stall_addr", imem_addr, 16'h000A);

    // ---------------- redirect with request pending ----------------
    cycle(1'b0, 1'b0, 16'h0041, 1'b0);
    check("disc_req", 16'(imem_req), 16'd1);
    check("disc_addr", imem_addr, 16'h000A);
    check("disc_valid", 16'(valid_out), 16'd0);
    check("disc_ir", ir_out, 16'h0000);
    cycle(1'b0, 1'b1, 16'h0, 1'b0);
    check("disc_addr2", imem_addr, 16'h000A);
    cycle(1'b0, 1'b1, 16'h0, 1'b1);
    check("disc_drop_valid", 16'(valid_out), 16'd0);
    check("disc_drop_ir", ir_out, 16'h0000);
    check("redir_addr", imem_addr, 16'h0040);
    cycle(1'b0, 1'b1, 16'h0, 1'b1);
    check("redir_pc", pc_out, 16'h0040);
    check("redir_ir", ir_out, 16'h0040 ^ KEY);
    check("redir_valid", 16'(valid_out), 16'd1);

    // ---------------- redirect and stall on the same edge ----------------
    cycle(1'b1, 1'b0, 16'h0100, 1'b1);
    check("jstall_ir", ir_out, 16'h0000);
    check("jstall_valid", 16'(valid_out), 16'd0);
    check("jstall_addr", imem_addr, 16'h0100);
    check("jstall_req", 16'(imem_req), 16'd1);
    cycle(1'b0, 1'b1, 16'h0, 1'b1);
    check("jstall_pc", pc_out, 16'h0100);

    // ---------------- PC wrap ----------------
    cycle(1'b0, 1'b0, 16'hFFFE, 1'b1);
    check("wrap_addr", imem_addr, 16'hFFFE);
    cycle(1'b0, 1'b1, 16'h0, 1'b1);
    check("wrap_pc0", pc_out, 16'hFFFE);
    check("wrap_opcp2_0", OPCP2, 16'h0000);
    cycle(1'b0, 1'b1, 16'h0, 1'b1);
    check("wrap_pc1", pc_out, 16'h0000);
    check("wrap_opcp2_1", OPCP2, 16'h0002);
    check("wrap_addr1", imem_addr, 16'h0002);

    // ---------------- reset while a request is outstanding ----------------
    cycle(1'b0, 1'b1, 16'h0, 1'b0);
    check("pend_req", 16'(imem_req), 16'd1);
    check("pend_addr", imem_addr, 16'h0002);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_pc", pc_out, 16'h0000);
    check("mid_rst_ir", ir_out, 16'h0000);
    check("mid_rst_opcp2", OPCP2, 16'h0000);
    check("mid_rst_valid", 16'(valid_out), 16'd0);
    check("mid_rst_req", 16'(imem_req), 16'd0);
    check("mid_rst_addr", imem_addr, 16'h0000);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_addr", imem_addr, 16'h0000);
    check("post_rst_req", 16'(imem_req), 16'd1);
    cycle(1'b0, 1'b1, 16'h0, 1'b1);
    check("post_rst_pc", pc_out, 16'h0000);
    check("post_rst_valid", 16'(valid_out), 16'd1);

    // ---------------- randomized run ----------------
    consumed_before = consumed;
    for (int i = 0; i < 3000; i++) begin
      rs  = ($urandom_range(0, 3) == 0);
      rj  = ($urandom_range(0, 19) != 0);
      rr  = ($urandom_range(0, 9) < 6);
      rnp = 16'($urandom);
      cycle(rs, rj, rnp, rr);
    end
    check("progress", 16'(consumed - consumed_before > 300), 16'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
